// File: rtl/prt_dptx_lnk_skew.sv
// DP TX link output stage: gates lanes to the active lane count and applies
// symbol-granular inter-lane skew ahead of the PHY symbol bus.
module prt_dptx_lnk_skew #(
   parameter int P_LANES = 4,
   parameter int P_SPL   = 2,
   parameter int P_SKEW  = 2,
   parameter int P_SYM   = 11
) (
   input  logic                           CLK_IN,
   input  logic                           RST_IN,
   input  logic                           LNK_CKE_IN,
   input  logic [1:0]                     CFG_LANES_IN,
   input  logic                           CFG_SKEW_EN_IN,
   input  logic [P_LANES*P_SPL*P_SYM-1:0] LNK_DAT_IN,
   output logic [P_LANES*P_SPL*P_SYM-1:0] LNK_DAT_OUT,
   output logic                           STA_CFG_CHG_OUT
);
   localparam int SW  = P_SPL*P_SYM;
   localparam int D   = (P_LANES-1)*P_SKEW;
   localparam int STW = (D+P_SPL)*P_SYM;
   localparam logic [2:0] LANES_MAX = 3'(P_LANES);

   logic [2:0]            lanes_r;
   logic [2:0]            lanes_s;
   logic [2:0]            lanes_req_s;
   logic                  skew_en_r;
   logic                  cfg_chg_s;
   logic                  chg_r;
   logic [P_LANES*SW-1:0] dat_r;
   logic [P_LANES*SW-1:0] dat_nxt_s;

   // Decode the requested lane count, cap it, and detect a config change
   always_comb begin
      case (CFG_LANES_IN)
         2'd0:    lanes_req_s = 3'd1;
         2'd1:    lanes_req_s = 3'd2;
         default: lanes_req_s = 3'd4;
      endcase
      if (lanes_req_s > LANES_MAX) begin
         lanes_s = LANES_MAX;
      end else begin
         lanes_s = lanes_req_s;
      end
      cfg_chg_s = (lanes_s != lanes_r) || (CFG_SKEW_EN_IN != skew_en_r);
   end

   for (genvar gi = 0; gi < P_LANES; gi++) begin : g_lane
      logic           act_s;
      logic [SW-1:0]  cur_s;
      logic [SW-1:0]  out_s;
      logic [STW-1:0] stream_s;
      int             dly_s;

      // Idle lanes feed zeros so their history stays cleared
      always_comb begin
         act_s = (3'(gi) < lanes_s);
         if (act_s) begin
            cur_s = LNK_DAT_IN[gi*SW +: SW];
         end else begin
            cur_s = '0;
         end
         if (CFG_SKEW_EN_IN) begin
            dly_s = gi*P_SKEW;
         end else begin
            dly_s = 0;
         end
      end

      // Output symbol j reads the stream dly_s symbols before the current slot
      always_comb begin
         out_s = '0;
         for (int j = 0; j < P_SPL; j++) begin
            out_s[j*P_SYM +: P_SYM] = stream_s[(D + j - dly_s)*P_SYM +: P_SYM];
         end
      end

      if (D > 0) begin : g_hist
         logic [D*P_SYM-1:0] hist_r;
         logic [D*P_SYM-1:0] hist_use_s;

         // A config change reads history as zero for the cycle it is accepted
         assign hist_use_s = cfg_chg_s ? '0 : hist_r;
         assign stream_s   = {cur_s, hist_use_s};

         // Keep the newest D symbols of the stream for the next enabled cycle
         always_ff @(posedge CLK_IN or negedge RST_IN) begin
            if (!RST_IN) begin
               hist_r <= '0;
            end else if (LNK_CKE_IN) begin
               hist_r <= stream_s[SW +: D*P_SYM];
            end
         end
      end else begin : g_nohist
         assign stream_s = cur_s;
      end

      assign dat_nxt_s[gi*SW +: SW] = out_s;
   end

   // Output and config registers; only enabled cycles advance them
   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         dat_r     <= '0;
         chg_r     <= 1'b0;
         lanes_r   <= 3'd1;
         skew_en_r <= 1'b0;
      end else if (LNK_CKE_IN) begin
         dat_r     <= dat_nxt_s;
         chg_r     <= cfg_chg_s;
         lanes_r   <= lanes_s;
         skew_en_r <= CFG_SKEW_EN_IN;
      end else begin
         chg_r     <= 1'b0;
      end
   end

   assign LNK_DAT_OUT     = dat_r;
   assign STA_CFG_CHG_OUT = chg_r;

endmodule
